// File: rtl/sw_array_feeder_if.sv
// Bus bundle between the feeder, the host-side sequence buffers and PE 0 / per-PE store strobes.
// master = feeder side, slave = host/PE side.
interface sw_array_feeder_if #(
    parameter int NUM_PE  = 6,
    parameter int SCORE_W = 10
);
    logic               q_valid;
    logic [1:0]         q_data;
    logic               q_ready;
    logic               r_valid;
    logic [1:0]         r_data;
    logic               r_ready;
    logic [1:0]         S_out;
    logic [NUM_PE-1:0]  store_S_out;
    logic [1:0]         T_out;
    logic [SCORE_W-1:0] V_out;
    logic [SCORE_W-1:0] F_out;
    logic               init_out;

    modport master (
        input  q_valid, q_data, r_valid, r_data,
        output q_ready, r_ready, S_out, store_S_out, T_out, V_out, F_out, init_out
    );

    modport slave (
        output q_valid, q_data, r_valid, r_data,
        input  q_ready, r_ready, S_out, store_S_out, T_out, V_out, F_out, init_out
    );
endinterface

// File: rtl/sw_array_feeder.sv
// Smith-Waterman chain feeder: loads one query base per PE, streams reference bases into PE 0,
// then drains the chain before pulsing done.
module sw_array_feeder #(
    parameter int                 NUM_PE  = 6,
    parameter int                 SCORE_W = 10,
    parameter int                 LEN_W   = 16,
    parameter logic [SCORE_W-1:0] V_INIT  = '0,
    parameter logic [SCORE_W-1:0] F_INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] ref_len,
    output logic             busy,
    output logic             done,
    sw_array_feeder_if.master bus
);
    localparam int IDX_W = $clog2(NUM_PE) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   ref_len_q, ref_len_d;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d;
    logic [LEN_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [LEN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [1:0]         s_q, s_d;
    logic [NUM_PE-1:0]  store_q, store_d;
    logic [1:0]         t_q, t_d;
    logic [SCORE_W-1:0] v_q, v_d;
    logic [SCORE_W-1:0] f_q, f_d;
    logic               init_q, init_d;
    logic               done_q, done_d;
    logic               q_acc, r_acc;

    // Ready is decoded purely from state so valid never loops back combinationally.
    assign bus.q_ready = (state_q == LOAD);
    assign bus.r_ready = (state_q == STREAM);
    assign q_acc       = bus.q_valid && (state_q == LOAD);
    assign r_acc       = bus.r_valid && (state_q == STREAM);

    always_comb begin
        state_d     = state_q;
        ref_len_d   = ref_len_q;
        load_idx_d  = load_idx_q;
        ref_cnt_d   = ref_cnt_q;
        drain_cnt_d = drain_cnt_q;
        s_d         = s_q;
        store_d     = '0;
        t_d         = t_q;
        v_d         = v_q;
        f_d         = f_q;
        init_d      = 1'b0;
        done_d      = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ref_len_d   = ref_len;
                    load_idx_d  = '0;
                    ref_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (q_acc) begin
                    s_d        = bus.q_data;
                    store_d    = NUM_PE'(1) << load_idx_q;
                    load_idx_d = load_idx_q + IDX_W'(1);
                    if (load_idx_q == IDX_W'(NUM_PE - 1)) begin
                        state_d     = (ref_len_q == '0) ? DRAIN : STREAM;
                        drain_cnt_d = '0;
                    end
                end
            end
            STREAM: begin
                if (r_acc) begin
                    t_d       = bus.r_data;
                    v_d       = V_INIT;
                    f_d       = F_INIT;
                    init_d    = 1'b1;
                    ref_cnt_d = ref_cnt_q + LEN_W'(1);
                    // ref_cnt_q <= ref_len_q-1 here, so the increment cannot wrap.
                    if (ref_cnt_d == ref_len_q) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LEN_W'(NUM_PE - 1)) state_d = DONE;
                else drain_cnt_d = drain_cnt_q + LEN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ref_len_q   <= '0;
            load_idx_q  <= '0;
            ref_cnt_q   <= '0;
            drain_cnt_q <= '0;
            s_q         <= '0;
            store_q     <= '0;
            t_q         <= '0;
            v_q         <= '0;
            f_q         <= '0;
            init_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_len_q   <= ref_len_d;
            load_idx_q  <= load_idx_d;
            ref_cnt_q   <= ref_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s_q         <= s_d;
            store_q     <= store_d;
            t_q         <= t_d;
            v_q         <= v_d;
            f_q         <= f_d;
            init_q      <= init_d;
            done_q      <= done_d;
        end
    end

    assign bus.S_out       = s_q;
    assign bus.store_S_out = store_q;
    assign bus.T_out       = t_q;
    assign bus.V_out       = v_q;
    assign bus.F_out       = f_q;
    assign bus.init_out    = init_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
endmodule

// File: tb/tb_sw_array_feeder.sv
// Bench for sw_array_feeder: directed and randomized runs scored against a count-based model
// of query loads, reference accepts and the fixed drain latency before done.
module tb_sw_array_feeder;
    localparam int NUM_PE  = 6;
    localparam int SCORE_W = 10;
    localparam int LEN_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] ref_len;
    logic             busy, done;

    sw_array_feeder_if #(.NUM_PE(NUM_PE), .SCORE_W(SCORE_W)) bus ();

    sw_array_feeder #(.NUM_PE(NUM_PE), .SCORE_W(SCORE_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_len(ref_len),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]        qseq [NUM_PE];
    logic [1:0]        rseq [$];
    logic [1:0]        exp_s, exp_t;
    logic [NUM_PE-1:0] exp_st;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ":store"}, bus.store_S_out, '0);
        chk({tag, ":init"},  bus.init_out, 0);
        chk({tag, ":done"},  done, 0);
        chk({tag, ":busy"},  busy, 0);
        chk({tag, ":qrdy"},  bus.q_ready, 0);
        chk({tag, ":rrdy"},  bus.r_ready, 0);
    endtask

    // vmode: 0 valids held high, 1 r_valid toggles 1,0,1,0..., 2 random valids
    task automatic run(input int len, input int vmode, input int abort_at, input string tag);
        int li = 0, ri = 0, last = -1;
        bit aq, ar, tog = 1'b1, finished = 1'b0, aborted = 1'b0;
        ref_len = LEN_W'(len);
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":busy_start"}, busy, 1);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (cyc == abort_at) begin
                start = 1'b0;
                rst   = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                chk_idle({tag, ":abort"});
                chk({tag, ":abort_S"}, bus.S_out, 0);
                chk({tag, ":abort_T"}, bus.T_out, 0);
                exp_s = '0;
                exp_t = '0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk({tag, ":abort_nodone"}, done, 0);
                    chk({tag, ":abort_idle"}, busy, 0);
                end
                aborted = 1'b1;
                break;
            end
            bus.q_valid = (vmode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
            bus.q_data  = (li < NUM_PE) ? qseq[li] : 2'($urandom);
            if (vmode == 1) begin
                bus.r_valid = tog;
                if (li == NUM_PE) tog = ~tog;
            end else if (vmode == 2) bus.r_valid = ($urandom_range(0, 9) < 6);
            else bus.r_valid = 1'b1;
            bus.r_data = (ri < len) ? rseq[ri] : 2'($urandom);
            // start pulses while busy must be ignored, including their ref_len
            start = (last < 0 || cyc < last + 7) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (start) ref_len = LEN_W'($urandom_range(0, 40));

            chk({tag, ":q_ready"}, bus.q_ready, (li < NUM_PE));
            chk({tag, ":r_ready"}, bus.r_ready, (li == NUM_PE && ri < len));
            aq = bus.q_valid && (li < NUM_PE);
            ar = bus.r_valid && (li == NUM_PE) && (ri < len);
            tick();

            exp_st = '0;
            if (aq) begin
                exp_s  = qseq[li];
                exp_st = NUM_PE'(1) << li;
                li++;
                if (li == NUM_PE && len == 0) last = cyc;
            end
            if (ar) begin
                exp_t = rseq[ri];
                ri++;
                if (ri == len) last = cyc;
            end
            chk({tag, ":store"}, bus.store_S_out, exp_st);
            chk({tag, ":S"},     bus.S_out, exp_s);
            chk({tag, ":init"},  bus.init_out, ar);
            chk({tag, ":T"},     bus.T_out, exp_t);
            chk({tag, ":V"},     bus.V_out, 0);
            chk({tag, ":F"},     bus.F_out, 0);
            chk({tag, ":done"},  done, (last >= 0 && cyc == last + NUM_PE + 1));
            chk({tag, ":busy"},  busy, !(last >= 0 && cyc >= last + NUM_PE + 1));
            if (last >= 0 && cyc == last + NUM_PE + 1) begin
                finished = 1'b1;
                break;
            end
        end
        start       = 1'b0;
        bus.q_valid = 1'b0;
        bus.r_valid = 1'b0;
        chk({tag, ":completed"}, finished | aborted, 1);
        if (finished) begin
            tick();
            chk({tag, ":done_once"}, done, 0);
            chk({tag, ":idle_after"}, busy, 0);
        end
    endtask

    task automatic rand_seqs(input int len);
        foreach (qseq[i]) qseq[i] = 2'($urandom);
        rseq.delete();
        for (int i = 0; i < len; i++) rseq.push_back(2'($urandom));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        ref_len     = '0;
        bus.q_valid = 1'b0;
        bus.q_data  = '0;
        bus.r_valid = 1'b0;
        bus.r_data  = '0;
        exp_s       = '0;
        exp_t       = '0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset:S", bus.S_out, 0);
        chk("reset:T", bus.T_out, 0);
        chk("reset:V", bus.V_out, 0);
        chk("reset:F", bus.F_out, 0);
        rst = 1'b0;
        tick();

        qseq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0};
        rseq = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
        run(8, 0, -1, "directed");

        rand_seqs(6);
        run(6, 1, -1, "backpressure");

        rand_seqs(0);
        run(0, 0, -1, "len0");

        rand_seqs(1);
        run(1, 2, -1, "len1");

        rand_seqs(12);
        run(12, 0, 10, "abort");

        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, 25);
            rand_seqs(len);
            run(len, 2, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
